// File: rtl/bsram_pkg.sv
// Shared widths and request layout for the BSRAM port master.
package bsram_pkg;

    localparam int BSRAM_A_SIZE = 15;
    localparam int BSRAM_W_SIZE = 8;
    localparam int BSRAM_DEPTH  = 32768;

    typedef struct packed {
        logic                    we;
        logic [BSRAM_A_SIZE-1:0] addr;
        logic [BSRAM_W_SIZE-1:0] wdata;
    } bsram_req_t;

    function automatic logic is_read(input bsram_req_t r);
        return !r.we;
    endfunction

endpackage

// File: rtl/bsram_rsp_fifo.sv
// Synchronous read-response FIFO; head word is presented combinationally on o_dout.
module bsram_rsp_fifo
    import bsram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = BSRAM_W_SIZE,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap for free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/bsram_port_master.sv
// Initiator for one BSRAM port: registered issue, read-latency tracking and
// credit-limited issue so every read's data always has a FIFO slot waiting.
module bsram_port_master
    import bsram_pkg::*;
#(
    parameter int A_SIZE    = BSRAM_A_SIZE,
    parameter int W_SIZE    = BSRAM_W_SIZE,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [A_SIZE-1:0] req_addr,
    input  logic [W_SIZE-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_SIZE-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic              mem_reset,
    output logic [A_SIZE-1:0] mem_ad,
    output logic [W_SIZE-1:0] mem_din,
    input  logic [W_SIZE-1:0] mem_dout
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    bsram_req_t    w_req;
    bsram_req_t    r_issue;
    logic          r_ce;
    logic          r_run;
    logic [RD_LAT:0] r_vld_pipe;
    logic [CW-1:0] r_used;
    logic          w_fire;
    logic          w_rd_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;

    assign w_req     = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign w_fire    = req_valid && req_ready;
    assign w_rd_fire = w_fire && is_read(w_req);
    assign w_pop     = rsp_valid && rsp_ready;
    // Stage 0 is the cycle the strobe is on the BSRAM pins; data lands RD_LAT edges later.
    assign w_push    = r_vld_pipe[RD_LAT];

    // Writes stall too when credits run out, keeping issue strictly in order.
    assign req_ready = r_run && (r_used < CW'(RSP_DEPTH));
    assign rsp_valid = !w_empty;

    assign mem_ce    = r_ce;
    assign mem_wre   = r_issue.we;
    assign mem_ad    = r_issue.addr;
    assign mem_din   = r_issue.wdata;
    assign mem_reset = ~resetn;
    assign mem_oce   = (RD_LAT >= 2) ? r_vld_pipe[1] : 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run   <= 1'b0;
            r_ce    <= 1'b0;
            r_issue <= '0;
        end else begin
            r_run <= 1'b1;
            r_ce  <= w_fire;
            if (w_fire) r_issue    <= w_req;
            else        r_issue.we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld_pipe <= '0;
            r_used     <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_fire};
            case ({w_rd_fire, w_pop})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: ;
            endcase
        end
    end

    bsram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (W_SIZE)
    ) u_rsp_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (mem_dout),
        .i_pop   (w_pop),
        .o_dout  (rsp_rdata),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(w_push && w_full));
    a_credit_ok:   assert property (@(posedge clk) disable iff (!resetn) r_used >= w_count);

endmodule

// File: tb/tb_bsram_port_master.sv
// Bench: two masters (RD_LAT=2 and RD_LAT=1), each on its own behavioural BSRAM port model.
module tb_bsram_port_master;

    logic        clk;
    logic        resetn;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [14:0] req_addr, mem_ad;
    logic [7:0]  req_wdata, rsp_rdata, mem_din, mem_dout;
    logic        mem_ce, mem_oce, mem_wre, mem_reset;

    logic        l1_req_valid, l1_req_ready, l1_req_we, l1_rsp_valid, l1_rsp_ready;
    logic [14:0] l1_req_addr, l1_mem_ad;
    logic [7:0]  l1_req_wdata, l1_rsp_rdata, l1_mem_din, l1_mem_dout;
    logic        l1_mem_ce, l1_mem_oce, l1_mem_wre, l1_mem_reset;

    int vectors = 0;
    int miscompares = 0;
    int n_rsp = 0;
    logic [7:0] ref_mem [0:32767];
    logic [7:0] ref1_mem [0:32767];
    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];

    bsram_port_master #(.RD_LAT(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_reset(mem_reset),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    bsram_port_master #(.RD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata),
        .mem_ce(l1_mem_ce), .mem_oce(l1_mem_oce), .mem_wre(l1_mem_wre), .mem_reset(l1_mem_reset),
        .mem_ad(l1_mem_ad), .mem_din(l1_mem_din), .mem_dout(l1_mem_dout)
    );

    // DP_BSRAM8 port A model: array read register, then optional output register.
    logic [7:0] mem_a [0:32767];
    logic [7:0] a_q, a_o;
    always @(posedge clk) begin
        if (mem_reset) begin
            a_q <= 8'h00;
            a_o <= 8'h00;
        end else begin
            if (mem_ce) begin
                if (mem_wre) mem_a[mem_ad] <= mem_din;
                else         a_q <= mem_a[mem_ad];
            end
            if (mem_oce) a_o <= a_q;
        end
    end
    assign mem_dout = a_o;

    logic [7:0] mem_b [0:32767];
    logic [7:0] b_q;
    always @(posedge clk) begin
        if (l1_mem_reset) b_q <= 8'h00;
        else if (l1_mem_ce) begin
            if (l1_mem_wre) mem_b[l1_mem_ad] <= l1_mem_din;
            else            b_q <= mem_b[l1_mem_ad];
        end
    end
    assign l1_mem_dout = b_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard sample at the falling edge: pops are checked before new reads are queued.
    task automatic sb_sample();
        logic [7:0] e;
        if (!resetn) begin
            exp_q.delete();
            exp1_q.delete();
            return;
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_rsp: got unexpected %h, none outstanding", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e) begin
                    miscompares++;
                    $display("FAIL sb_rsp: got %h expected %h", rsp_rdata, e);
                end
            end
        end
        if (req_valid && req_ready) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
        end
        if (l1_rsp_valid && l1_rsp_ready) begin
            vectors++;
            if (exp1_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_rsp_l1: got unexpected %h", l1_rsp_rdata);
            end else begin
                e = exp1_q.pop_front();
                if (l1_rsp_rdata !== e) begin
                    miscompares++;
                    $display("FAIL sb_rsp_l1: got %h expected %h", l1_rsp_rdata, e);
                end
            end
        end
        if (l1_req_valid && l1_req_ready) begin
            if (l1_req_we) ref1_mem[l1_req_addr] = l1_req_wdata;
            else           exp1_q.push_back(ref1_mem[l1_req_addr]);
        end
        vectors++;
        if (l1_mem_oce !== 1'b0) begin
            miscompares++;
            $display("FAIL oce_rdlat1: got %b expected 0", l1_mem_oce);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [14:0] addr, input logic [7:0] wd);
        logic ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        for (int t = 0; t < 50; t++) begin
            ok = req_ready;
            cyc();
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout: req_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int t = 0; t < 100 && (exp_q.size() != 0 || rsp_valid); t++) cyc();
        vectors++;
        if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: outstanding got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        l1_req_valid = 0; l1_req_we = 0; l1_req_addr = '0; l1_req_wdata = '0; l1_rsp_ready = 0;
        #2;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (mem_ce !== 1'b0) begin miscompares++; $display("FAIL rst_mem_ce: got %b expected 0", mem_ce); end
        vectors++; if (mem_wre !== 1'b0) begin miscompares++; $display("FAIL rst_mem_wre: got %b expected 0", mem_wre); end
        vectors++; if (mem_oce !== 1'b0) begin miscompares++; $display("FAIL rst_mem_oce: got %b expected 0", mem_oce); end
        vectors++; if (mem_ad !== 15'h0) begin miscompares++; $display("FAIL rst_mem_ad: got %h expected 0", mem_ad); end
        vectors++; if (mem_din !== 8'h0) begin miscompares++; $display("FAIL rst_mem_din: got %h expected 0", mem_din); end
        vectors++; if (mem_reset !== 1'b1) begin miscompares++; $display("FAIL rst_mem_reset: got %b expected 1", mem_reset); end
        cyc(); cyc();
        vectors++; if (l1_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_l1_ready: got %b expected 0", l1_req_ready); end
        resetn = 1'b1;
        cyc();
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b expected 1", req_ready); end
        vectors++; if (mem_reset !== 1'b0) begin miscompares++; $display("FAIL post_rst_mem_reset: got %b expected 0", mem_reset); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        issue(1'b1, 15'h0010, 8'hA5);
        issue(1'b0, 15'h0010, 8'h00);
        vectors++;
        if (!(mem_ce === 1'b1 && mem_wre === 1'b0 && mem_ad === 15'h0010)) begin
            miscompares++;
            $display("FAIL rd_strobe: got ce=%b wre=%b ad=%h expected 1 0 0010", mem_ce, mem_wre, mem_ad);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_lat_early: cycle %0d got valid %b expected 0", k, rsp_valid); end
            if (k == 1) begin
                vectors++;
                if (mem_oce !== 1'b1) begin miscompares++; $display("FAIL rd_oce: got %b expected 1", mem_oce); end
            end
            cyc();
        end
        vectors++;
        if (!(rsp_valid === 1'b1 && rsp_rdata === 8'hA5)) begin
            miscompares++;
            $display("FAIL rd_lat_data: got valid=%b data=%h expected 1 a5", rsp_valid, rsp_rdata);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        int base;
        logic ok;
        for (int k = 0; k < 8; k++) issue(1'b1, 15'(k), 8'(k) ^ 8'h3C);
        rsp_ready = 1'b0;
        base = n_rsp;
        n = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0;
        for (int t = 0; t < 10; t++) begin
            ok = req_ready;
            cyc();
            if (ok) begin n++; req_addr = 15'(n); end
        end
        vectors++; if (n != 4) begin miscompares++; $display("FAIL credit_fires: got %0d expected 4", n); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL credit_ready: got %b expected 0", req_ready); end
        vectors++;
        if (!(rsp_valid === 1'b1 && rsp_rdata === 8'h3C)) begin
            miscompares++;
            $display("FAIL hold_head: got valid=%b data=%h expected 1 3c", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 60 && n < 8; t++) begin
            ok = req_ready;
            cyc();
            if (ok) begin
                n++;
                if (n == 8) req_valid = 1'b0;
                else        req_addr = 15'(n);
            end
        end
        req_valid = 1'b0;
        vectors++; if (n != 8) begin miscompares++; $display("FAIL b2b_fires: got %0d expected 8", n); end
        drain();
        vectors++; if (n_rsp - base != 8) begin miscompares++; $display("FAIL b2b_count: got %0d expected 8", n_rsp - base); end
    endtask

    task automatic test_raw();
        rsp_ready = 1'b1;
        issue(1'b1, 15'h7FFF, 8'hEE);
        issue(1'b1, 15'h7FFF, 8'h11);
        issue(1'b0, 15'h7FFF, 8'h00);
        for (int t = 0; t < 10 && !rsp_valid; t++) cyc();
        vectors++;
        if (!(rsp_valid === 1'b1 && rsp_rdata === 8'h11)) begin
            miscompares++;
            $display("FAIL raw: got valid=%b data=%h expected 1 11", rsp_valid, rsp_rdata);
        end
        drain();
    endtask

    task automatic test_fire_pop();
        logic ok;
        rsp_ready = 1'b0;
        issue(1'b0, 15'h0, 8'h0);
        issue(1'b0, 15'h1, 8'h0);
        issue(1'b0, 15'h2, 8'h0);
        repeat (4) cyc();
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fp_three: got ready %b expected 1", req_ready); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h3; rsp_ready = 1'b1;
        ok = req_ready;
        cyc();
        req_valid = 1'b0; rsp_ready = 1'b0;
        vectors++;
        if (!(ok === 1'b1 && req_ready === 1'b1)) begin
            miscompares++;
            $display("FAIL fp_same_cycle: got fired=%b ready=%b expected 1 1", ok, req_ready);
        end
        issue(1'b0, 15'h4, 8'h0);
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL fp_full: got ready %b expected 0", req_ready); end
        repeat (4) cyc();
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL fp_hold: got ready %b expected 0", req_ready); end
        drain();
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp_ready = 1'b0;
        issue(1'b0, 15'h5, 8'h0);
        issue(1'b0, 15'h6, 8'h0);
        repeat (4) cyc();
        issue(1'b0, 15'h7, 8'h0);
        issue(1'b0, 15'h0, 8'h0);
        resetn = 1'b0;
        #1;
        vectors++;
        if (!(rsp_valid === 1'b0 && mem_ce === 1'b0 && req_ready === 1'b0)) begin
            miscompares++;
            $display("FAIL mid_rst: got valid=%b ce=%b ready=%b expected 0 0 0", rsp_valid, mem_ce, req_ready);
        end
        cyc(); cyc();
        resetn = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (rsp_valid) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL mid_rst_stale: got %0d responses expected 0", seen); end
    endtask

    task automatic test_rdlat1();
        l1_rsp_ready = 1'b1;
        l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_addr = 15'h0010; l1_req_wdata = 8'hA5;
        vectors++; if (l1_req_ready !== 1'b1) begin miscompares++; $display("FAIL l1_ready: got %b expected 1", l1_req_ready); end
        cyc();
        l1_req_we = 1'b0;
        cyc();
        l1_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (l1_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL l1_lat_early: cycle %0d got %b expected 0", k, l1_rsp_valid); end
            cyc();
        end
        vectors++;
        if (!(l1_rsp_valid === 1'b1 && l1_rsp_rdata === 8'hA5)) begin
            miscompares++;
            $display("FAIL l1_lat_data: got valid=%b data=%h expected 1 a5", l1_rsp_valid, l1_rsp_rdata);
        end
        cyc(); cyc();
        vectors++;
        if (exp1_q.size() != 0 || l1_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL l1_drain: outstanding got %0d expected 0", exp1_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_raw();
        test_fire_pop();
        test_reset_mid();
        test_rdlat1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
